// File: rtl/reg_access_arbiter.sv
// Shares the PID register-file port between requester 0 (UART) and requester 1 (SPI).
// Optional build macro ARB_FIXED_PRIO_EN: requester 0 always wins contention instead of round-robin.
module reg_access_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int RO_BASE  = 14
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_write,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        req_ready,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [ADDR_W-1:0] mem_r_addr,
    output logic [DATA_W-1:0] mem_w_data,
    input  logic [DATA_W-1:0] mem_r_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;

    localparam logic [ADDR_W:0] NUM_REGS_W = NUM_REGS[ADDR_W:0];
    localparam logic [ADDR_W:0] RO_BASE_W  = RO_BASE[ADDR_W:0];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < NUM_REGS_W;
    endfunction

    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < RO_BASE_W;
    endfunction

    state_t              state_q;
    state_t              state_d;
    logic                take;
    logic                win_id;

    logic                gnt_id_p0;
    logic                wr_p0;
    logic [ADDR_W-1:0]   addr_p0;
    logic [DATA_W-1:0]   wdata_p0;

    logic [1:0]          rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;

`ifdef ARB_FIXED_PRIO_EN
    assign win_id = ~req_valid[0];
`else
    logic last_grant_q;

    // On contention the requester that did not win last time gets the port.
    assign win_id = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
`endif

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    take    = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS:  state_d = wr_p0 ? IDLE : CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_id_p0   <= 1'b0;
            wr_p0       <= 1'b0;
            addr_p0     <= '0;
            wdata_p0    <= '0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;

            // Stage p0: latch the granted request for the access phase.
            if (take) begin
                gnt_id_p0 <= win_id;
                wr_p0     <= req_write[win_id];
                addr_p0   <= win_id ? req_addr1 : req_addr0;
                wdata_p0  <= win_id ? req_wdata1 : req_wdata0;
`ifndef ARB_FIXED_PRIO_EN
                last_grant_q <= win_id;
`endif
            end

            // Response stage: write ack after ACCESS, read data after CAPTURE.
            if (state_q == ACCESS && wr_p0) begin
                rsp_valid_q <= gnt_id_p0 ? 2'b10 : 2'b01;
                rsp_err_q   <= ~writable(addr_p0);
            end
            if (state_q == CAPTURE) begin
                rsp_valid_q <= gnt_id_p0 ? 2'b10 : 2'b01;
                rsp_rdata_q <= in_range(addr_p0) ? mem_r_data : '0;
                rsp_err_q   <= ~in_range(addr_p0);
            end
        end
    end

    // All outputs are forced quiet while reset is high, aborting any in-flight write.
    assign req_ready  = (take && !reset) ? (win_id ? 2'b10 : 2'b01) : 2'b00;
    assign mem_we     = !reset && (state_q == ACCESS) && wr_p0 && writable(addr_p0);
    assign mem_w_addr = reset ? '0 : addr_p0;
    assign mem_r_addr = reset ? '0 : addr_p0;
    assign mem_w_data = reset ? '0 : wdata_p0;
    assign rsp_valid  = reset ? 2'b00 : rsp_valid_q;
    assign rsp_rdata  = reset ? '0 : rsp_rdata_q;
    assign rsp_err    = reset ? 1'b0 : rsp_err_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Bench for reg_access_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (grant decisions, scheduled memory and response events per cycle).
`timescale 1ns/1ps
module tb_reg_access_arbiter;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
    logic [7:0]  req_addr0, req_addr1, mem_w_addr, mem_r_addr;
    logic [15:0] req_wdata0, req_wdata1, rsp_rdata, mem_w_data, mem_r_data;
    logic        rsp_err, mem_we;

    reg_access_arbiter dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_we     (mem_we),
        .mem_w_addr (mem_w_addr),
        .mem_r_addr (mem_r_addr),
        .mem_w_data (mem_w_data),
        .mem_r_data (mem_r_data)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // requester-side pending requests
    logic        rst_drv;
    logic [1:0]  p_vld, p_wr;
    logic [7:0]  p_addr [2];
    logic [15:0] p_wd   [2];

    // register file attached to the memory port (registered read)
    logic [15:0] mem_arr [16];

    always @(posedge clk_in) begin
        mem_r_data <= (mem_r_addr < 8'd16) ? mem_arr[mem_r_addr[3:0]] : (16'hD000 | {8'h00, mem_r_addr});
        if (mem_we && mem_w_addr < 8'd16) mem_arr[mem_w_addr[3:0]] = mem_w_data;
    end

    // model state
    logic [15:0] shadow [16];
    int          next_free = 0;
    bit          last_g    = 1'b1;
    bit          s_mem [16];
    bit          s_we  [16];
    logic [7:0]  s_addr[16];
    logic [15:0] s_wd  [16];
    logic [1:0]  s_rv  [16];
    logic [15:0] s_rd  [16];
    bit          s_err [16];
    logic [15:0] m_last_rd = 16'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk_in) begin
        int         k, win, k1, k2, k3;
        logic [1:0] e_rdy;
        logic [7:0] a;
        logic       wr;
        logic [15:0] wd;
        k = cyc % 16;
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                s_mem[i] = 0; s_we[i] = 0; s_rv[i] = 2'b00; s_err[i] = 0;
            end
            next_free = cyc + 1;
            last_g    = 1'b1;
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_mem_we", 32'(mem_we), 0);
            chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
            chk("rst_rsp_err", 32'(rsp_err), 0);
            chk("rst_mem_w_addr", 32'(mem_w_addr), 0);
            chk("rst_mem_r_addr", 32'(mem_r_addr), 0);
            chk("rst_mem_w_data", 32'(mem_w_data), 0);
        end else begin
            if (s_we[k]) shadow[s_addr[k][3:0]] = s_wd[k];
            e_rdy = 2'b00;
            if (cyc >= next_free && req_valid != 2'b00) begin
`ifdef ARB_FIXED_PRIO_EN
                win = req_valid[0] ? 0 : 1;
`else
                if (req_valid == 2'b11) win = last_g ? 0 : 1;
                else                    win = req_valid[1] ? 1 : 0;
`endif
                last_g     = (win == 1);
                e_rdy[win] = 1'b1;
                a  = (win == 1) ? req_addr1 : req_addr0;
                wd = (win == 1) ? req_wdata1 : req_wdata0;
                wr = req_write[win];
                k1 = (cyc + 1) % 16;
                k2 = (cyc + 2) % 16;
                k3 = (cyc + 3) % 16;
                s_mem[k1]  = 1;
                s_we[k1]   = wr && (a < 8'd14);
                s_addr[k1] = a;
                s_wd[k1]   = wd;
                if (wr) begin
                    s_rv[k2]  = (win == 1) ? 2'b10 : 2'b01;
                    s_rd[k2]  = 16'h0;
                    s_err[k2] = !(a < 8'd14);
                    next_free = cyc + 2;
                end else begin
                    s_rv[k3]  = (win == 1) ? 2'b10 : 2'b01;
                    s_rd[k3]  = (a < 8'd16) ? shadow[a[3:0]] : 16'h0;
                    s_err[k3] = !(a < 8'd16);
                    m_last_rd = s_rd[k3];
                    next_free = cyc + 3;
                end
                p_vld[win] = 1'b0;
            end
            chk("req_ready", 32'(req_ready), 32'(e_rdy));
            chk("mem_we", 32'(mem_we), 32'(s_we[k]));
            if (s_mem[k]) begin
                chk("mem_w_addr", 32'(mem_w_addr), 32'(s_addr[k]));
                chk("mem_r_addr", 32'(mem_r_addr), 32'(s_addr[k]));
                if (s_we[k]) chk("mem_w_data", 32'(mem_w_data), 32'(s_wd[k]));
            end
            chk("rsp_valid", 32'(rsp_valid), 32'(s_rv[k]));
            if (s_rv[k] != 2'b00) begin
                chk("rsp_rdata", 32'(rsp_rdata), 32'(s_rd[k]));
                chk("rsp_err", 32'(rsp_err), 32'(s_err[k]));
            end
            s_mem[k] = 0; s_we[k] = 0; s_rv[k] = 2'b00; s_err[k] = 0;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
        reset      = rst_drv;
        req_valid  = p_vld;
        req_write  = p_wr;
        req_addr0  = p_addr[0];
        req_addr1  = p_addr[1];
        req_wdata0 = p_wd[0];
        req_wdata1 = p_wd[1];
        @(negedge clk_in);
        #1;
    endtask

    task automatic issue(input int n, input logic wr, input logic [7:0] a, input logic [15:0] d);
        p_vld[n]  = 1'b1;
        p_wr[n]   = wr;
        p_addr[n] = a;
        p_wd[n]   = d;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (p_vld != 2'b00 && guard < 50) begin
            tick();
            guard++;
        end
        chk("drain_pending", 32'(p_vld), 0);
        repeat (4) tick();
    endtask

    initial begin
        int ng;
        logic [1:0] g_exp;
        logic       wr;
        logic [7:0] a;
        rst_drv = 1'b1;
        p_vld = 2'b00; p_wr = 2'b00;
        p_addr[0] = 8'h0; p_addr[1] = 8'h0; p_wd[0] = 16'h0; p_wd[1] = 16'h0;
        reset = 1'b1; req_valid = 2'b00; req_write = 2'b00;
        req_addr0 = 8'h0; req_addr1 = 8'h0; req_wdata0 = 16'h0; req_wdata1 = 16'h0;
        for (int i = 0; i < 16; i++) begin
            mem_arr[i] = 16'h1000 + 16'(i);
            shadow[i]  = 16'h1000 + 16'(i);
        end
        mem_arr[3] = 16'hBEEF;
        shadow[3]  = 16'hBEEF;

        repeat (3) tick();
        rst_drv = 1'b0;
        tick();
        chk("idle_ready", 32'(req_ready), 0);
        chk("idle_rsp_valid", 32'(rsp_valid), 0);
        chk("idle_mem_we", 32'(mem_we), 0);

        // write addr 0 from requester 0
        issue(0, 1'b1, 8'd0, 16'h1234);
        tick(); chk("t1_ready", 32'(req_ready), 1);
        tick(); chk("t1_we", 32'(mem_we), 1); chk("t1_waddr", 32'(mem_w_addr), 0);
                chk("t1_wdata", 32'(mem_w_data), 'h1234);
        tick(); chk("t1_rsp", 32'(rsp_valid), 1); chk("t1_err", 32'(rsp_err), 0);

        // read addr 3 from requester 1
        issue(1, 1'b0, 8'd3, 16'h0);
        tick(); chk("t2_ready", 32'(req_ready), 2); chk("t2_model_rd", 32'(m_last_rd), 'hBEEF);
        tick(); chk("t2_raddr", 32'(mem_r_addr), 3);
        tick(); chk("t2_no_rsp_yet", 32'(rsp_valid), 0);
        tick(); chk("t3_rsp", 32'(rsp_valid), 2); chk("t2_rdata", 32'(rsp_rdata), 'hBEEF);
                chk("t2_err", 32'(rsp_err), 0);

        // contention after reset
        rst_drv = 1'b1; repeat (2) tick(); rst_drv = 1'b0;
        ng = 0;
        for (int t = 0; t < 30 && ng < 4; t++) begin
            for (int n = 0; n < 2; n++) if (!p_vld[n]) issue(n, 1'b0, 8'd1, 16'h0);
            tick();
            if (req_ready != 2'b00) begin
`ifdef ARB_FIXED_PRIO_EN
                g_exp = 2'b01;
`else
                g_exp = (ng % 2 == 1) ? 2'b10 : 2'b01;
`endif
                chk($sformatf("t3_grant%0d", ng), 32'(req_ready), 32'(g_exp));
                ng++;
            end
        end
        chk("t3_grant_count", 32'(ng), 4);
        drain();

        // blocked writes: read-only and out of range
        issue(0, 1'b1, 8'd14, 16'hFFFF);
        tick(); chk("t4a_ready", 32'(req_ready), 1);
        tick(); chk("t4a_we", 32'(mem_we), 0);
        tick(); chk("t4a_rsp", 32'(rsp_valid), 1); chk("t4a_err", 32'(rsp_err), 1);
        issue(1, 1'b1, 8'd20, 16'h5555);
        tick(); chk("t4b_ready", 32'(req_ready), 2);
        tick(); chk("t4b_we", 32'(mem_we), 0);
        tick(); chk("t4b_rsp", 32'(rsp_valid), 2); chk("t4b_err", 32'(rsp_err), 1);

        // out-of-range read is masked
        issue(0, 1'b0, 8'd16, 16'h0);
        repeat (4) tick();
        chk("t5_rsp", 32'(rsp_valid), 1); chk("t5_rdata", 32'(rsp_rdata), 0);
        chk("t5_err", 32'(rsp_err), 1);

        // reset during ACCESS of a write aborts it
        issue(0, 1'b1, 8'd5, 16'hAAAA);
        tick(); chk("t6_ready", 32'(req_ready), 1);
        rst_drv = 1'b1;
        tick(); chk("t6_we_reset", 32'(mem_we), 0);
        rst_drv = 1'b0;
        issue(1, 1'b0, 8'd5, 16'h0);
        tick(); chk("t6_no_rsp", 32'(rsp_valid), 0); chk("t6_we_after", 32'(mem_we), 0);
                chk("t6_regrant", 32'(req_ready), 2); chk("t6_model_rd", 32'(m_last_rd), 'h1005);
        repeat (3) tick();
        chk("t6_rsp", 32'(rsp_valid), 2); chk("t6_rdata", 32'(rsp_rdata), 'h1005);

        // randomized traffic
        for (int t = 0; t < 3000; t++) begin
            rst_drv = ($urandom_range(0, 199) == 0);
            for (int n = 0; n < 2; n++) begin
                if (!p_vld[n] && $urandom_range(0, 99) < 45) begin
                    wr = 1'($urandom_range(0, 1));
                    a  = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 17)) : 8'($urandom_range(0, 255));
                    issue(n, wr, a, 16'($urandom));
                end
            end
            tick();
        end
        rst_drv = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
